// File: rtl/cbus_arbiter_n_pkg.sv
// Shared types for the cbus N-port arbiter: request/response structs, arbitration mode
// and FSM state encoding.
package cbus_arbiter_n_pkg;

    parameter int unsigned CBUS_MAX_PORTS = 8;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_t;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [63:0] data;
        logic [7:0]  strb;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_n_rr_picker.sv
// Combinational winner search: round-robin starting at rr_ptr_i, or fixed priority
// (lowest index wins) when ARB_MODE is ARB_FIXED.
module cbus_arbiter_n_rr_picker
    import cbus_arbiter_n_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter arb_mode_t   ARB_MODE  = ARB_RR
) (
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr_i,
    output logic                         found_o,
    output logic [$clog2(NUM_PORTS)-1:0] idx_o
);
    localparam int unsigned IdxW = $clog2(NUM_PORTS);

    logic [IdxW-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == ARB_FIXED) begin
                cand = IdxW'(k);
            end else begin
                cand = IdxW'((32'(rr_ptr_i) + k) % NUM_PORTS);
            end
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter_n.sv
// N-port cbus arbiter: locks one upstream master onto the downstream port for a whole
// burst, then returns to idle for one cycle before the next grant.
module cbus_arbiter_n
    import cbus_arbiter_n_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter arb_mode_t   ARB_MODE  = ARB_RR
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  cbus_req_t  [NUM_PORTS-1:0]   ireqs,
    output cbus_resp_t [NUM_PORTS-1:0]   iresps,
    output cbus_req_t                    oreq,
    input  cbus_resp_t                   oresp,
    output logic [$clog2(NUM_PORTS)-1:0] grant,
    output logic                         busy
);
    localparam int unsigned IdxW = $clog2(NUM_PORTS);

    arb_state_e           state_q, state_d;
    logic [IdxW-1:0]      grant_q, grant_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]      pick_idx;
    logic                 pick_found;
    logic [NUM_PORTS-1:0] req_valid;
    logic                 done;

    always_comb begin
        req_valid = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            req_valid[i] = ireqs[i].valid;
        end
    end

    cbus_arbiter_n_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  (ARB_MODE)
    ) u_picker (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx)
    );

    assign done = oresp.ready && oresp.last;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StBusy;
                    grant_d = pick_idx;
                end
            end
            StBusy: begin
                // Completion always goes through idle, so a re-grant waits one cycle.
                if (done) begin
                    state_d = StIdle;
                    if (ARB_MODE == ARB_RR) begin
                        rr_ptr_d = (grant_q == IdxW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Outputs depend only on registered state in idle: no valid-to-oreq path.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state_q == StBusy) begin
            oreq            = ireqs[grant_q];
            iresps[grant_q] = oresp;
        end
    end

    assign busy  = (state_q == StBusy);
    assign grant = grant_q;

    a_owner_holds_valid: assert property (@(posedge clk) disable iff (!resetn)
        (state_q == StBusy) |-> ireqs[grant_q].valid);

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Self-checking bench for cbus_arbiter_n: a round-robin and a fixed-priority instance
// (3 ports each) share stimulus; the unused one is held in reset.
module tb_cbus_arbiter_n;
    import cbus_arbiter_n_pkg::*;

    logic             clk;
    logic             resetn_a, resetn_b;
    cbus_req_t  [2:0] ireqs;
    cbus_resp_t       oresp;
    cbus_resp_t [2:0] iresps_a, iresps_b, obs_iresps;
    cbus_req_t        oreq_a, oreq_b, obs_oreq;
    logic [1:0]       grant_a, grant_b, obs_grant;
    logic             busy_a, busy_b, obs_busy;
    logic             use_fixed;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    cbus_arbiter_n #(.NUM_PORTS(3), .ARB_MODE(ARB_RR)) u_dut_rr (
        .clk    (clk),
        .resetn (resetn_a),
        .ireqs  (ireqs),
        .iresps (iresps_a),
        .oreq   (oreq_a),
        .oresp  (oresp),
        .grant  (grant_a),
        .busy   (busy_a)
    );

    cbus_arbiter_n #(.NUM_PORTS(3), .ARB_MODE(ARB_FIXED)) u_dut_fixed (
        .clk    (clk),
        .resetn (resetn_b),
        .ireqs  (ireqs),
        .iresps (iresps_b),
        .oreq   (oreq_b),
        .oresp  (oresp),
        .grant  (grant_b),
        .busy   (busy_b)
    );

    assign obs_busy   = use_fixed ? busy_b   : busy_a;
    assign obs_grant  = use_fixed ? grant_b  : grant_a;
    assign obs_oreq   = use_fixed ? oreq_b   : oreq_a;
    assign obs_iresps = use_fixed ? iresps_b : iresps_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

    task automatic set_req(input int p, input logic wr, input int len);
        ireqs[p].valid = 1'b1;
        ireqs[p].write = wr;
        ireqs[p].addr  = 32'h1000_0000 + 32'(p) * 32'h100;
        ireqs[p].len   = 8'(len);
        ireqs[p].size  = 3'd3;
        ireqs[p].data  = {32'hC0DE_0000 + 32'(p), 32'h0};
        ireqs[p].strb  = 8'hFF;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn_a = 1'b0;
        resetn_b = 1'b0;
        ireqs    = '0;
        oresp    = '0;
        repeat (2) @(negedge clk);
        if (use_fixed) resetn_b = 1'b1;
        else resetn_a = 1'b1;
    endtask

    // Slave model: waits for a grant, serves len+1 ready beats, reports what it saw.
    task automatic serve_burst(input bit drop, input int inj_beat, input int inj_port,
                               input int inj_len, input logic [63:0] dpat,
                               output int g, output int waited, output int bad,
                               output bit idle_after);
        int len;
        g = -1; waited = 0; bad = 0; idle_after = 1'b0;
        @(negedge clk);
        while (!obs_busy && waited < 64) begin
            waited++;
            @(negedge clk);
        end
        if (!obs_busy) return;
        g = int'(obs_grant);
        if (g > 2) begin
            bad = 1;
            return;
        end
        len = int'(ireqs[g].len);
        for (int b = 0; b <= len; b++) begin
            if (b == inj_beat) set_req(inj_port, 1'b0, inj_len);
            oresp.ready = 1'b1;
            oresp.last  = (b == len);
            oresp.data  = dpat + 64'(b);
            #1;
            if (!obs_busy || obs_oreq !== ireqs[g]) bad++;
            for (int j = 0; j < 3; j++) begin
                if (j == g) begin
                    if (obs_iresps[j] !== oresp) bad++;
                end else if (obs_iresps[j] !== '0) begin
                    bad++;
                end
            end
            @(posedge clk);
            #1;
            oresp = '0;
            if (b == len) begin
                idle_after = !obs_busy;
                if (drop) ireqs[g].valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        use_fixed = 1'b0;
        resetn_a  = 1'b0;
        resetn_b  = 1'b0;
        ireqs     = '0;
        oresp     = '0;
        for (int p = 0; p < 3; p++) set_req(p, 1'b0, 3);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %0b/%0b, need 0/0", busy_a, busy_b);
        end
        n_cmp++;
        if (oreq_a !== '0 || oreq_b !== '0) begin
            n_bad++;
            $display("FAIL reset_oreq: got %h, need 0", oreq_a);
        end
        n_cmp++;
        if (iresps_a !== '0 || iresps_b !== '0) begin
            n_bad++;
            $display("FAIL reset_iresps: got %h, need 0", iresps_a);
        end
        n_cmp++;
        if (grant_a !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_grant: got %0d, need 0", grant_a);
        end
    endtask

    task automatic test_rr();
        int g, w, bad, e;
        bit idle;
        use_fixed = 1'b0;
        do_reset();
        @(negedge clk);
        for (int p = 0; p < 3; p++) set_req(p, 1'b0, 3);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        #1;
        n_cmp++;
        if (busy_a !== 1'b0 || oreq_a.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_no_comb_path: busy=%0b oreq.valid=%0b, need 0/0",
                     busy_a, oreq_a.valid);
        end
        for (int k = 0; k < 4; k++) begin
            serve_burst(1'b0, -1, 0, 0, 64'h1111_0000_0000_0000, g, w, bad, idle);
            e = exp_q.pop_front();
            n_cmp++;
            if (g != e) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got %0d, need %0d", k, g, e);
            end
            n_cmp++;
            if (w != ((k == 0) ? 0 : 1)) begin
                n_bad++;
                $display("FAIL rr_idle_gap[%0d]: got %0d, need %0d", k, w, (k == 0) ? 0 : 1);
            end
            n_cmp++;
            if (bad != 0 || !idle) begin
                n_bad++;
                $display("FAIL rr_burst[%0d]: bad beats %0d idle %0b, need 0/1", k, bad, idle);
            end
        end
        ireqs = '0;
    endtask

    task automatic test_lock();
        int g, w, bad, e;
        bit idle;
        use_fixed = 1'b0;
        do_reset();
        @(negedge clk);
        set_req(1, 1'b1, 15);
        exp_q.push_back(1); exp_q.push_back(0);
        serve_burst(1'b1, 2, 0, 3, 64'h2222_0000_0000_0000, g, w, bad, idle);
        e = exp_q.pop_front();
        n_cmp++;
        if (g != e || bad != 0 || !idle) begin
            n_bad++;
            $display("FAIL lock_port1: grant %0d bad %0d idle %0b, need %0d/0/1", g, bad, idle, e);
        end
        serve_burst(1'b1, -1, 0, 0, 64'h3333_0000_0000_0000, g, w, bad, idle);
        e = exp_q.pop_front();
        n_cmp++;
        if (g != e || w != 1 || bad != 0) begin
            n_bad++;
            $display("FAIL lock_next: grant %0d gap %0d bad %0d, need %0d/1/0", g, w, bad, e);
        end
        ireqs = '0;
    endtask

    task automatic test_fixed();
        int g, w, bad, e;
        bit idle;
        use_fixed = 1'b1;
        do_reset();
        @(negedge clk);
        set_req(2, 1'b0, 1);
        set_req(1, 1'b0, 1);
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(2);
        for (int k = 0; k < 3; k++) begin
            serve_burst(1'b1, (k == 0) ? 0 : -1, 0, 1, 64'h4444_0000_0000_0000,
                        g, w, bad, idle);
            e = exp_q.pop_front();
            n_cmp++;
            if (g != e || bad != 0 || !idle) begin
                n_bad++;
                $display("FAIL fixed_order[%0d]: grant %0d bad %0d, need %0d/0", k, g, bad, e);
            end
        end
        ireqs = '0;
        use_fixed = 1'b0;
    endtask

    task automatic test_routing();
        int w;
        use_fixed = 1'b0;
        do_reset();
        @(negedge clk);
        set_req(2, 1'b0, 0);
        w = 0;
        @(negedge clk);
        while (!busy_a && w < 32) begin
            w++;
            @(negedge clk);
        end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'hDEAD_BEEF_0000_0001;
        #1;
        n_cmp++;
        if (busy_a !== 1'b1 || grant_a !== 2'd2) begin
            n_bad++;
            $display("FAIL route_grant: busy %0b grant %0d, need 1/2", busy_a, grant_a);
        end
        n_cmp++;
        if (iresps_a[2].data !== 64'hDEAD_BEEF_0000_0001 || iresps_a[2].ready !== 1'b1) begin
            n_bad++;
            $display("FAIL route_data: got %h, need deadbeef00000001", iresps_a[2].data);
        end
        n_cmp++;
        if (iresps_a[0] !== '0 || iresps_a[1] !== '0) begin
            n_bad++;
            $display("FAIL route_others: got %h/%h, need 0", iresps_a[0], iresps_a[1]);
        end
        n_cmp++;
        if (oreq_a.addr !== 32'h1000_0200 || oreq_a.valid !== 1'b1) begin
            n_bad++;
            $display("FAIL route_oreq: addr %h, need 10000200", oreq_a.addr);
        end
        @(posedge clk);
        #1;
        oresp = '0;
        ireqs = '0;
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL route_single_beat_done: busy %0b, need 0", busy_a);
        end
    endtask

    task automatic test_reset_mid_burst();
        int g, w, bad, e;
        bit idle;
        use_fixed = 1'b0;
        do_reset();
        @(negedge clk);
        set_req(1, 1'b0, 0);
        serve_burst(1'b1, -1, 0, 0, 64'h5555_0000_0000_0000, g, w, bad, idle);
        set_req(0, 1'b0, 7);
        w = 0;
        @(negedge clk);
        while (!busy_a && w < 32) begin
            w++;
            @(negedge clk);
        end
        n_cmp++;
        if (busy_a !== 1'b1 || grant_a !== 2'd0) begin
            n_bad++;
            $display("FAIL rr_wrap_grant: busy %0b grant %0d, need 1/0", busy_a, grant_a);
        end
        for (int b = 0; b < 5; b++) begin
            oresp.ready = 1'b1;
            oresp.data  = 64'(b);
            @(posedge clk);
            #1;
            oresp = '0;
            @(negedge clk);
        end
        oresp.ready = 1'b1;
        oresp.data  = 64'h6666;
        #2;
        resetn_a = 1'b0;
        #1;
        n_cmp++;
        if (busy_a !== 1'b0 || oreq_a !== '0 || iresps_a !== '0 || grant_a !== 2'd0) begin
            n_bad++;
            $display("FAIL midburst_reset: busy %0b grant %0d oreq.valid %0b, need 0/0/0",
                     busy_a, grant_a, oreq_a.valid);
        end
        ireqs = '0;
        oresp = '0;
        @(negedge clk);
        resetn_a = 1'b1;
        @(negedge clk);
        set_req(1, 1'b0, 0);
        set_req(2, 1'b0, 0);
        exp_q.push_back(1); exp_q.push_back(2);
        for (int k = 0; k < 2; k++) begin
            serve_burst(1'b1, -1, 0, 0, 64'h7777_0000_0000_0000, g, w, bad, idle);
            e = exp_q.pop_front();
            n_cmp++;
            if (g != e || bad != 0) begin
                n_bad++;
                $display("FAIL post_reset_grant[%0d]: got %0d bad %0d, need %0d/0", k, g, bad, e);
            end
        end
        ireqs = '0;
    endtask

    initial begin
        test_reset();
        test_rr();
        test_lock();
        test_fixed();
        test_routing();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
